// File: rtl/csa_resolver_if.sv
// Handshake bus for csa_resolver: operand pair in, resolved result out.
interface csa_resolver_if #(
  parameter int unsigned WIDTH = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, sum_in, carry_in, out_ready,
    input  in_ready, out_valid, result
  );

  // Resolver side
  modport slave (
    input  in_valid, sum_in, carry_in, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/csa_resolver.sv
// Carry-propagate end of the carry-save datapath: adds the sum and carry vectors
// CHUNK bits per clock and presents the WIDTH+1-bit result with valid/ready.
module csa_resolver #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CHUNK = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  csa_resolver_if.slave  bus,
  output logic           busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             cin_q, cin_d;
  logic [WIDTH:0]   result_q, result_d;

  int unsigned      base;
  logic [CHUNK:0]   chunk_sum;

  // One chunk of the ripple: the slice selected by idx plus the carry from the previous chunk
  always_comb begin
    base      = 32'(idx_q) * CHUNK;
    chunk_sum = {1'b0, sum_q[base +: CHUNK]} + {1'b0, carry_q[base +: CHUNK]}
              + (CHUNK + 1)'(cin_q);
  end

  // Next-state: capture in IDLE, resolve one chunk per RUN cycle, hold in DONE
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    cin_d    = cin_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sum_d    = bus.sum_in;
          carry_d  = bus.carry_in;
          idx_d    = '0;
          cin_d    = 1'b0;
          result_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        result_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        cin_d = chunk_sum[CHUNK];
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          // Final carry lands in the extra top bit so nothing is truncated
          result_d[WIDTH] = chunk_sum[CHUNK];
          idx_d           = '0;
          state_d         = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sum_q    <= '0;
      carry_q  <= '0;
      idx_q    <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      cin_q    <= cin_d;
      result_q <= result_d;
    end
  end

  // Handshake outputs come straight from registered state, never from inputs
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign busy          = (state_q == StRun) || (state_q == StDone);

endmodule

// File: tb/tb_csa_resolver.sv
// Directed and randomised checks of csa_resolver for CHUNK=1 and CHUNK=5 builds.
module tb_csa_resolver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   sel = 0;   // 0: CHUNK=1 instance, 1: CHUNK=5 instance

  csa_resolver_if #(.WIDTH(5)) bus1 ();
  csa_resolver_if #(.WIDTH(5)) bus5 ();
  logic busy1, busy5;

  csa_resolver #(.WIDTH(5), .CHUNK(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1),
    .busy  (busy1)
  );

  csa_resolver #(.WIDTH(5), .CHUNK(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5),
    .busy  (busy5)
  );

  always #5 clk = ~clk;

  logic       m_in_ready, m_out_valid, m_busy;
  logic [5:0] m_result;
  assign m_in_ready  = sel ? bus5.in_ready  : bus1.in_ready;
  assign m_out_valid = sel ? bus5.out_valid : bus1.out_valid;
  assign m_result    = sel ? bus5.result    : bus1.result;
  assign m_busy      = sel ? busy5          : busy1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] s, input logic [4:0] c,
                       input logic r);
    if (sel == 0) begin
      bus1.in_valid = v; bus1.sum_in = s; bus1.carry_in = c; bus1.out_ready = r;
    end else begin
      bus5.in_valid = v; bus5.sum_in = s; bus5.carry_in = c; bus5.out_ready = r;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sel = k;
      #0;
      tests++;
      if (m_in_ready !== 1'b1) begin
        fails++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, m_in_ready);
      end
      tests++;
      if (m_out_valid !== 1'b0) begin
        fails++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, m_out_valid);
      end
      tests++;
      if (m_result !== 6'd0) begin
        fails++; $display("FAIL reset_result[%0d]: got %0d want 0", k, m_result);
      end
      tests++;
      if (m_busy !== 1'b0) begin
        fails++; $display("FAIL reset_busy[%0d]: got %b want 0", k, m_busy);
      end
    end
    sel = 0;
  endtask

  // 0 + 01110 = 14; out_valid after E0+5, in_ready after E0+6
  task automatic test_basic();
    sel = 0;
    drive(1'b1, 5'b00000, 5'b01110, 1'b1);
    step();
    drive(1'b0, 5'b11111, 5'b11111, 1'b1);
    tests++;
    if (m_in_ready !== 1'b0 || m_busy !== 1'b1) begin
      fails++; $display("FAIL basic_run_flags: in_ready=%b busy=%b want 0/1", m_in_ready, m_busy);
    end
    for (int i = 1; i < 5; i++) begin
      step();
      tests++;
      if (m_out_valid !== 1'b0) begin
        fails++; $display("FAIL basic_early_valid: cycle %0d out_valid=%b want 0", i, m_out_valid);
      end
    end
    step();
    tests++;
    if (m_out_valid !== 1'b1) begin
      fails++; $display("FAIL basic_valid: got %b want 1", m_out_valid);
    end
    tests++;
    if (m_result !== 6'd14) begin
      fails++; $display("FAIL basic_result: got %0d want 14", m_result);
    end
    step();
    tests++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_result !== 6'd14) begin
      fails++;
      $display("FAIL basic_return: in_ready=%b out_valid=%b result=%0d want 1/0/14",
               m_in_ready, m_out_valid, m_result);
    end
  endtask

  // 01111 + 11110 = 45, top bit from the final carry
  task automatic test_carry_out();
    sel = 0;
    drive(1'b1, 5'b01111, 5'b11110, 1'b1);
    step();
    drive(1'b0, 5'b00000, 5'b00000, 1'b1);
    for (int i = 0; i < 5; i++) step();
    tests++;
    if (m_out_valid !== 1'b1 || m_result !== 6'd45) begin
      fails++; $display("FAIL carry_out: valid=%b result=%0d want 1/45", m_out_valid, m_result);
    end
    tests++;
    if (m_result[5] !== 1'b1) begin
      fails++; $display("FAIL carry_out_msb: got %b want 1", m_result[5]);
    end
    step();
  endtask

  task automatic test_backpressure();
    sel = 0;
    drive(1'b1, 5'b01111, 5'b11110, 1'b0);
    step();
    drive(1'b0, 5'b00000, 5'b00000, 1'b0);
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (m_out_valid !== 1'b1 || m_result !== 6'd45 || m_in_ready !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold[%0d]: valid=%b result=%0d in_ready=%b want 1/45/0",
                 i, m_out_valid, m_result, m_in_ready);
      end
      // Pulse a new operand during DONE; it must be ignored
      drive((i == 1), 5'b00001, 5'b00001, 1'b0);
      step();
    end
    drive(1'b0, 5'b00000, 5'b00000, 1'b1);
    step();
    tests++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_result !== 6'd45) begin
      fails++;
      $display("FAIL backpressure_release: valid=%b in_ready=%b result=%0d want 0/1/45",
               m_out_valid, m_in_ready, m_result);
    end
    step();
    tests++;
    if (m_busy !== 1'b0) begin
      fails++; $display("FAIL backpressure_ignored_pulse: busy=%b want 0", m_busy);
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    drive(1'b1, 5'b01111, 5'b11110, 1'b1);
    step();
    drive(1'b0, 5'b00000, 5'b00000, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_result !== 6'd0 || m_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: in_ready=%b valid=%b result=%0d busy=%b want 1/0/0/0",
               m_in_ready, m_out_valid, m_result, m_busy);
    end
    drive(1'b1, 5'b00101, 5'b00010, 1'b1);
    step();
    drive(1'b0, 5'b00000, 5'b00000, 1'b1);
    for (int i = 0; i < 5; i++) step();
    tests++;
    if (m_out_valid !== 1'b1 || m_result !== 6'd7) begin
      fails++; $display("FAIL reset_mid_fresh: valid=%b result=%0d want 1/7", m_out_valid, m_result);
    end
    step();
  endtask

  // Single-chunk build: 10101 + 01010 = 31, valid one cycle after capture
  task automatic test_chunk5();
    sel = 1;
    drive(1'b1, 5'b10101, 5'b01010, 1'b1);
    step();
    drive(1'b0, 5'b00000, 5'b00000, 1'b1);
    tests++;
    if (m_busy !== 1'b1 || m_out_valid !== 1'b0) begin
      fails++; $display("FAIL chunk5_run: busy=%b valid=%b want 1/0", m_busy, m_out_valid);
    end
    step();
    tests++;
    if (m_out_valid !== 1'b1 || m_result !== 6'd31) begin
      fails++; $display("FAIL chunk5_result: valid=%b result=%0d want 1/31", m_out_valid, m_result);
    end
    step();
    tests++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
      fails++; $display("FAIL chunk5_return: in_ready=%b valid=%b want 1/0", m_in_ready, m_out_valid);
    end
    sel = 0;
  endtask

  task automatic test_random(input int which);
    logic [4:0] s, c;
    logic [5:0] exp;
    logic       r, done;
    int         cycles;
    sel = which;
    for (int n = 0; n < 1000; n++) begin
      s   = 5'($urandom);
      c   = 5'($urandom);
      exp = {1'b0, s} + {1'b0, c};
      drive(1'b1, s, c, 1'($urandom));
      step();
      // Scramble the inputs after capture; the result must not follow them
      drive(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      done   = 1'b0;
      cycles = 0;
      while (!done && cycles < 40) begin
        r = 1'($urandom);
        if (m_out_valid) begin
          tests++;
          if (m_result !== exp) begin
            fails++;
            $display("FAIL random[%0d] #%0d: %0d+%0d got %0d want %0d", which, n, s, c,
                     m_result, exp);
          end
          if (r) done = 1'b1;
        end
        drive(1'b0, 5'($urandom), 5'($urandom), r);
        step();
        cycles++;
      end
      tests++;
      if (!done || m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
        fails++;
        $display("FAIL random_handshake[%0d] #%0d: done=%b valid=%b in_ready=%b want 1/0/1",
                 which, n, done, m_out_valid, m_in_ready);
      end
    end
    sel = 0;
  endtask

  initial begin
    sel = 0;
    drive(1'b0, 5'b0, 5'b0, 1'b0);
    sel = 1;
    drive(1'b0, 5'b0, 5'b0, 1'b0);
    sel = 0;
    test_reset();
    test_basic();
    test_carry_out();
    test_backpressure();
    test_reset_mid();
    test_chunk5();
    test_random(0);
    test_random(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csa_resolver.md
Name: csa_resolver

Overview:
- Converts the redundant carry-save pair (sum vector, carry vector) produced by the carry-save adder stage back into a single binary result.
- It is the carry-propagate end of the carry-save datapath.
- It resolves CHUNK bits per clock, so the ripple is spread over several cycles instead of being one long combinational chain.
- Input and output both use valid/ready handshakes so it can sit between pipeline stages.

Parameters:
- WIDTH, 5, width of the sum_in and carry_in vectors (matches the 5-bit carry-save outputs); must be at least 1.
- CHUNK, 1, bits resolved per RUN cycle; WIDTH % CHUNK must be 0. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  sum_in/carry_in are valid.
- in_ready  output  1  block can accept an operand pair.
- sum_in  input  WIDTH  carry-save sum vector.
- carry_in  input  WIDTH  carry-save carry vector (already weight-aligned; bit 0 is normally 0, but any value is added as given).
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH+1  sum_in + carry_in, zero-extended, no truncation.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; in_ready=1, out_valid=0, busy=0, result=0. Internal chunk index and carry are cleared.
- Reset overrides everything, including mid-RUN and mid-DONE. A pending result is discarded and no partial result is ever presented.

State machine (states IDLE, RUN, DONE):
- IDLE:
  - in_ready=1.
  - On an edge where in_valid=1: capture sum_in and carry_in, set idx=0, cin=0, result=0, go to RUN.
  - in_ready is registered and derived from state only; it never depends combinationally on in_valid or out_ready.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge: compute {c, r} = s[idx*CHUNK +: CHUNK] + c_vec[idx*CHUNK +: CHUNK] + cin.
  - Write r into result[idx*CHUNK +: CHUNK], set cin=c, idx=idx+1.
  - On the edge processing idx=NCHUNK-1: also write result[WIDTH]=c, then go to DONE.
- DONE:
  - out_valid=1; result and out_valid are held stable while out_ready=0, for any number of cycles.
  - On an edge where out_ready=1: go to IDLE, out_valid=0. result keeps its last value until the next capture.
  - in_ready=0 in DONE. There is no same-cycle handoff to a new operand.

Timing:
- Capture edge E0. out_valid is first seen high after edge E0+NCHUNK.
- With out_ready held at 1, in_ready returns after edge E0+NCHUNK+1.
- Peak throughput is one result per NCHUNK+2 cycles.

Boundary conditions:
- in_valid while not in IDLE is ignored and does not alter captured operands. Upstream must hold in_valid until in_ready.
- out_ready while not in DONE has no effect.
- Changes to sum_in/carry_in after capture do not affect the result.
- All-ones inputs give a maximum result of 2*(2^WIDTH-1), which fits in WIDTH+1 bits.
- CHUNK=WIDTH degenerates to a single RUN cycle with identical handshake rules.

Test Plan:
- WIDTH=5, CHUNK=1; after reset, check in_ready=1, out_valid=0, result=0. Then apply sum_in=5'b00000, carry_in=5'b01110 (carry-save of 3+5+6) with in_valid=1, out_ready=1 -> out_valid after 5 cycles, result=6'd14; in_ready high again one cycle later.
- sum_in=5'b01111, carry_in=5'b11110 (carry-save of 15+15+15) -> result=6'b101101 (45), with result[5]=1 from the final carry.
- Backpressure: same operands as above, out_ready=0 for 4 cycles after out_valid -> result=45 and out_valid held constant; in_ready=0 throughout; a new in_valid pulse during DONE is ignored. With out_ready=1 -> IDLE next cycle.
- Reset mid-operation: assert rst_n=0 at the 3rd RUN cycle -> next cycle state IDLE, out_valid=0, result=0, in_ready=1. A fresh operand pair (sum 5'b00101, carry 5'b00010) then gives 7.
- CHUNK=5 build: sum 5'b10101, carry 5'b01010 -> out_valid one cycle after capture, result=6'd31.
- Randomised: 1000 random WIDTH-bit pairs with random out_ready stalls, for CHUNK in {1,5} -> every result equals sum_in+carry_in, with exactly one output per accepted input.
